run_controller: RTL and testbench
=================================

RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter CTR_WIDTH, default 32, width of sample count and captured counters.
REQ-002 SHALL have parameter LAT_WIDTH, default 8, width of pipeline latency setting.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  run request, honoured only in IDLE or DONE.
REQ-006 SHALL have port i_abort  input  1  terminate any run, return to IDLE.
REQ-007 SHALL have port i_num_samples  input  CTR_WIDTH  samples to score, sampled when start is accepted.
REQ-008 SHALL have port i_latency  input  LAT_WIDTH  DUT pipeline fill cycles, sampled when start is accepted.
REQ-009 SHALL have port i_event_ctr  input  32  scoreboard event count.
REQ-010 SHALL have port i_data_ctr  input  32  scoreboard data count.
REQ-011 SHALL have port o_stim_en  output  1  stimulus generator enable.
REQ-012 SHALL have port o_sb_reset  output  1  scoreboard reset pulse.
REQ-013 SHALL have port o_sb_freeze  output  1  scoreboard freeze.
REQ-014 SHALL have ports o_busy and o_done  output  1 each  run in progress / results valid.
REQ-015 SHALL have ports o_event_result and o_data_result  output  32 each  captured counters.

Function
REQ-016 SHALL implement states IDLE, CLEAR, FILL, RUN, CAPTURE, DONE; all outputs registered.
REQ-017 In IDLE/DONE, an i_start high at a clock edge SHALL latch i_num_samples and i_latency, clear o_done, and enter CLEAR.
REQ-018 CLEAR SHALL last exactly 1 cycle with o_sb_reset=1, o_sb_freeze=1, o_stim_en=0.
REQ-019 FILL SHALL last exactly latched-latency cycles with o_stim_en=1, o_sb_freeze=1; latency 0 SHALL skip FILL (CLEAR to RUN).
REQ-020 RUN SHALL last exactly latched-sample-count cycles with o_stim_en=1, o_sb_freeze=0; count 0 SHALL skip RUN.
REQ-021 CAPTURE SHALL last 1 cycle with o_stim_en=0, o_sb_freeze=1, and at its closing edge latch i_event_ctr/i_data_ctr into o_event_result/o_data_result.
REQ-022 DONE SHALL hold o_done=1, o_sb_freeze=1, o_stim_en=0 until accepted i_start or i_abort.
REQ-023 o_busy SHALL be 1 in CLEAR, FILL, RUN, CAPTURE; 0 in IDLE and DONE.
REQ-024 i_start outside IDLE/DONE SHALL be ignored.
REQ-025 i_abort SHALL, from any state, enter IDLE next edge: o_stim_en=0, o_sb_freeze=1, o_done=0, results unchanged; abort beats simultaneous start.
REQ-026 Cycle counters SHALL count down from latched value and never wrap; maximum count 2^CTR_WIDTH-1 SHALL be supported.
REQ-027 Input changes on i_num_samples/i_latency during a run SHALL not affect it.

Reset
REQ-028 reset SHALL asynchronously force IDLE, o_stim_en=0, o_sb_reset=0, o_sb_freeze=1, o_busy=0, o_done=0, results=0, internal counters=0.
REQ-029 reset mid-run SHALL abandon the run; no capture occurs.

Configuration
REQ-030 Macro RUN_CONTROLLER_COUNT_CHECK_EN defined SHALL add output o_count_err (1 bit), set at CAPTURE edge when i_data_ctr != latched sample count, cleared on accepted start, abort or reset.
REQ-031 Without RUN_CONTROLLER_COUNT_CHECK_EN, o_count_err SHALL not exist and no comparator SHALL be built.

Verification
REQ-032 samples=10, latency=3, scoreboard attached, start pulse -> sb_reset 1 cycle, 3 frozen stim cycles, 10 unfrozen cycles, o_data_result=10, o_done=1 16 cycles after start edge.
REQ-033 latency=0, samples=0 -> CLEAR then CAPTURE then DONE; o_data_result=0, stim_en never high.
REQ-034 Abort during RUN at sample 5 of 100 -> IDLE next edge, freeze=1, done=0, previous results retained.
REQ-035 Start re-pulsed during FILL, and start+abort same cycle from DONE -> first ignored, second gives IDLE.
REQ-036 Async reset asserted mid-RUN between clock edges -> outputs at reset values immediately, no capture.
REQ-037 With RUN_CONTROLLER_COUNT_CHECK_EN, i_data_ctr forced to 9 for samples=10 -> o_count_err=1 in DONE; next start clears it.

Source files
------------

// File: rtl/run_controller.sv
// Run sequencer for a scored test: clears the scoreboard, fills the DUT pipeline, runs N samples,
// then captures the scoreboard counters. Define RUN_CONTROLLER_COUNT_CHECK_EN to add o_count_err.
module run_controller #(
  parameter int unsigned CTR_WIDTH = 32,
  parameter int unsigned LAT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CTR_WIDTH-1:0] i_num_samples,
  input  logic [LAT_WIDTH-1:0] i_latency,
  input  logic [31:0]          i_event_ctr,
  input  logic [31:0]          i_data_ctr,
  output logic                 o_stim_en,
  output logic                 o_sb_reset,
  output logic                 o_sb_freeze,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [31:0]          o_event_result,
  output logic [31:0]          o_data_result
`ifdef RUN_CONTROLLER_COUNT_CHECK_EN
  ,
  output logic                 o_count_err
`endif
);

  // One counter serves both FILL and RUN, so it must hold the wider of the two settings.
  localparam int unsigned CntW = (CTR_WIDTH > LAT_WIDTH) ? CTR_WIDTH : LAT_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFill,
    StRun,
    StCapture,
    StDone
  } state_t;

  state_t               r_state, w_state_next;
  logic [CntW-1:0]      r_cnt, w_cnt_next;
  logic [CTR_WIDTH-1:0] r_samples;
  logic [LAT_WIDTH-1:0] r_latency;
  logic                 w_accept;
  logic                 w_capture;
  logic [CntW-1:0]      w_samples_ext;
  logic [CntW-1:0]      w_latency_ext;

  logic                 r_stim_en, r_sb_reset, r_sb_freeze, r_busy, r_done;
  logic                 w_stim_en_next, w_sb_reset_next, w_sb_freeze_next, w_busy_next;
  logic                 w_done_next;
  logic [31:0]          r_event_result, r_data_result;

  assign w_samples_ext = CntW'(r_samples);
  assign w_latency_ext = CntW'(r_latency);
  assign w_capture     = (r_state == StCapture) && !i_abort;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    if (i_abort) begin
      w_state_next = StIdle;
      w_cnt_next   = '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            w_state_next = StClear;
            w_accept     = 1'b1;
          end
        end
        StClear: begin
          if (r_latency != '0) begin
            w_state_next = StFill;
            w_cnt_next   = w_latency_ext;
          end else if (r_samples != '0) begin
            w_state_next = StRun;
            w_cnt_next   = w_samples_ext;
          end else begin
            w_state_next = StCapture;
          end
        end
        StFill: begin
          if (r_cnt > CntW'(1)) begin
            w_cnt_next = r_cnt - CntW'(1);
          end else if (r_samples != '0) begin
            w_state_next = StRun;
            w_cnt_next   = w_samples_ext;
          end else begin
            w_state_next = StCapture;
            w_cnt_next   = '0;
          end
        end
        StRun: begin
          if (r_cnt > CntW'(1)) begin
            w_cnt_next = r_cnt - CntW'(1);
          end else begin
            w_state_next = StCapture;
            w_cnt_next   = '0;
          end
        end
        StCapture: w_state_next = StDone;
        default:   w_state_next = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_stim_en_next   = (w_state_next == StFill) || (w_state_next == StRun);
    w_sb_reset_next  = (w_state_next == StClear);
    w_sb_freeze_next = (w_state_next != StRun);
    w_busy_next      = (w_state_next == StClear) || (w_state_next == StFill) ||
                       (w_state_next == StRun) || (w_state_next == StCapture);
    w_done_next      = (w_state_next == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_samples      <= '0;
      r_latency      <= '0;
      r_stim_en      <= 1'b0;
      r_sb_reset     <= 1'b0;
      r_sb_freeze    <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_event_result <= '0;
      r_data_result  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_stim_en   <= w_stim_en_next;
      r_sb_reset  <= w_sb_reset_next;
      r_sb_freeze <= w_sb_freeze_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      if (w_accept) begin
        r_samples <= i_num_samples;
        r_latency <= i_latency;
      end
      if (w_capture) begin
        r_event_result <= i_event_ctr;
        r_data_result  <= i_data_ctr;
      end
    end
  end

  assign o_stim_en      = r_stim_en;
  assign o_sb_reset     = r_sb_reset;
  assign o_sb_freeze    = r_sb_freeze;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_event_result = r_event_result;
  assign o_data_result  = r_data_result;

`ifdef RUN_CONTROLLER_COUNT_CHECK_EN
  localparam int unsigned CmpW = (CTR_WIDTH > 32) ? CTR_WIDTH : 32;

  logic r_count_err;
  logic w_count_mismatch;

  assign w_count_mismatch = CmpW'(i_data_ctr) != CmpW'(r_samples);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count_err <= 1'b0;
    end else if (w_accept || i_abort) begin
      r_count_err <= 1'b0;
    end else if (w_capture) begin
      r_count_err <= w_count_mismatch;
    end
  end

  assign o_count_err = r_count_err;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: stimulus queues expected run summaries, a negedge monitor
// tallies phase cycles and checks each summary when o_done rises.
module tb_run_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_abort;
  logic [31:0] i_num_samples;
  logic [7:0]  i_latency;
  logic [31:0] i_event_ctr, i_data_ctr;
  logic        o_stim_en, o_sb_reset, o_sb_freeze, o_busy, o_done;
  logic [31:0] o_event_result, o_data_result;
`ifdef RUN_CONTROLLER_COUNT_CHECK_EN
  logic        o_count_err;
`endif

  always #5 clk = ~clk;

  run_controller dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_num_samples (i_num_samples),
    .i_latency     (i_latency),
    .i_event_ctr   (i_event_ctr),
    .i_data_ctr    (i_data_ctr),
    .o_stim_en     (o_stim_en),
    .o_sb_reset    (o_sb_reset),
    .o_sb_freeze   (o_sb_freeze),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_event_result(o_event_result),
    .o_data_result (o_data_result)
`ifdef RUN_CONTROLLER_COUNT_CHECK_EN
    ,
    .o_count_err   (o_count_err)
`endif
  );

  // Attached scoreboard: events = stimulus cycles, data = unfrozen stimulus cycles.
  logic [31:0] sb_event, sb_data;
  logic        force_en;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_event <= '0;
      sb_data  <= '0;
    end else if (o_sb_reset) begin
      sb_event <= '0;
      sb_data  <= '0;
    end else begin
      if (o_stim_en) sb_event <= sb_event + 1;
      if (o_stim_en && !o_sb_freeze) sb_data <= sb_data + 1;
    end
  end
  assign i_event_ctr = sb_event;
  assign i_data_ctr  = force_en ? 32'd9 : sb_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int unsigned lat;
    int unsigned samples;
    int unsigned cycles;
    logic [31:0] data_res;
    logic [31:0] event_res;
    logic        cerr;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge and queues the run summary the monitor should see.
  task automatic start_run(input int unsigned lat, input int unsigned samples,
                           input logic forced);
    exp_t e;
    e.lat       = lat;
    e.samples   = samples;
    e.cycles    = lat + samples + 3;  // CLEAR + FILL + RUN + CAPTURE, done seen in next cycle
    e.data_res  = forced ? 32'd9 : samples;
    e.event_res = lat + samples;
    e.cerr      = forced ? 1'b1 : (samples != 9 ? 1'b1 : 1'b0);
    e.cerr      = forced ? 1'b1 : 1'b0;
    exp_q.push_back(e);
    i_num_samples = samples;
    i_latency     = 8'(lat);
    i_start       = 1'b1;
    tick();
    i_start       = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!o_done && k < 400) begin
      tick();
      k++;
    end
    if (!o_done) chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic chk_idle(input string name, input logic [31:0] data_r,
                          input logic [31:0] event_r);
    chk({name, "_stim_en"}, o_stim_en, 0);
    chk({name, "_sb_reset"}, o_sb_reset, 0);
    chk({name, "_freeze"}, o_sb_freeze, 1);
    chk({name, "_busy"}, o_busy, 0);
    chk({name, "_done"}, o_done, 0);
    chk({name, "_data_result"}, o_data_result, data_r);
    chk({name, "_event_result"}, o_event_result, event_r);
  endtask

  // Monitor: per-phase cycle tallies, compared against the queued summary when a run completes.
  int unsigned run_cyc = 0, n_rst = 0, n_fill = 0, n_run = 0, n_cap = 0;
  logic        prev_done = 1'b0, prev_sb_reset = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_sb_reset) begin
        if (prev_sb_reset) begin
          n_rst++;
          run_cyc++;
        end else begin
          run_cyc = 1;
          n_rst   = 1;
          n_fill  = 0;
          n_run   = 0;
          n_cap   = 0;
        end
      end else if (run_cyc != 0) begin
        run_cyc++;
        if (o_stim_en && o_sb_freeze) n_fill++;
        if (o_stim_en && !o_sb_freeze) n_run++;
        if (o_busy && !o_stim_en) n_cap++;
      end
      if (o_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_cycles_to_done", run_cyc, e.cycles);
          chk("mon_sb_reset_cycles", n_rst, 1);
          chk("mon_fill_cycles", n_fill, e.lat);
          chk("mon_run_cycles", n_run, e.samples);
          chk("mon_capture_cycles", n_cap, 1);
          chk("mon_data_result", o_data_result, e.data_res);
          chk("mon_event_result", o_event_result, e.event_res);
          chk("mon_done_busy", o_busy, 0);
          chk("mon_done_stim_en", o_stim_en, 0);
          chk("mon_done_freeze", o_sb_freeze, 1);
`ifdef RUN_CONTROLLER_COUNT_CHECK_EN
          chk("mon_count_err", o_count_err, e.cerr);
`endif
        end
        run_cyc = 0;
      end
      prev_done     = o_done;
      prev_sb_reset = o_sb_reset;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    i_start       = 1'b0;
    i_abort       = 1'b0;
    i_num_samples = '0;
    i_latency     = '0;
    force_en      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset", 32'd0, 32'd0);
    reset = 1'b0;
    tick();

    // Nominal run; settings changed mid-run must not matter.
    start_run(3, 10, 1'b0);
    i_num_samples = 50;
    i_latency     = 7;
    wait_done("nominal");

    start_run(0, 0, 1'b0);
    wait_done("zero_zero");
    start_run(0, 4, 1'b0);
    wait_done("no_fill");
    start_run(2, 0, 1'b0);
    wait_done("no_run");

    // A second start during FILL is ignored.
    start_run(5, 6, 1'b0);
    tick();
    tick();
    i_num_samples = 2;
    i_latency     = 1;
    i_start       = 1'b1;
    tick();
    i_start       = 1'b0;
    wait_done("restart_in_fill");

    // Start and abort together from DONE: abort wins.
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk_idle("start_abort", 32'd6, 32'd11);
    repeat (3) tick();
    chk("start_abort_stays_idle", o_busy, 0);

    // Abort in the fifth RUN cycle of a 100-sample run.
    i_num_samples = 100;
    i_latency     = 2;
    i_start       = 1'b1;
    tick();
    i_start       = 1'b0;
    repeat (7) tick();
    chk("abort_pre_in_run", {o_stim_en, o_sb_freeze}, 2'b10);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk_idle("abort_run", 32'd6, 32'd11);
    repeat (5) tick();
    chk("abort_stays_idle", o_busy, 0);

    // Asynchronous reset between edges during RUN.
    i_num_samples = 20;
    i_latency     = 1;
    i_start       = 1'b1;
    tick();
    i_start       = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    chk_idle("async_reset", 32'd0, 32'd0);
    #3;
    reset = 1'b0;
    repeat (30) tick();
    chk_idle("after_reset", 32'd0, 32'd0);

`ifdef RUN_CONTROLLER_COUNT_CHECK_EN
    force_en = 1'b1;
    start_run(3, 10, 1'b1);
    wait_done("count_err_set");
    tick();
    force_en = 1'b0;
    start_run(0, 2, 1'b0);
    chk("count_err_cleared", o_count_err, 0);
    wait_done("count_err_clear_run");
`endif

    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
